// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and stage-state enum for pipeline stage registers
package pipe_pkg;

  localparam logic [31:0] PIPE_NOP_IR = 32'h0000_0000;

  localparam int PIPE_DEFAULT_DATA_WIDTH = 32;
  localparam int PIPE_DEFAULT_NUM_FIELDS = 2;
  localparam int PIPE_DEFAULT_IR_WIDTH   = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - enable-and-clear register holding one {IR, data} entry
module pipe_entry #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a flushed entry never keeps a same-cycle payload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register, optional skid entry via PIPE_STAGE_SKID_EN
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DEFAULT_DATA_WIDTH,
  parameter int NUM_FIELDS = PIPE_DEFAULT_NUM_FIELDS,
  parameter int IR_WIDTH   = PIPE_DEFAULT_IR_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IR_WIDTH-1:0]              in_IR,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IR_WIDTH-1:0]              out_IR,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] out_data
);

  localparam int DW_ALL = NUM_FIELDS * DATA_WIDTH;
  localparam int PW     = IR_WIDTH + DW_ALL;

  stage_state_e state, state_n;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic          main_load;
  logic          main_clear;

  assign in_payload = {in_IR, in_data};

`ifdef PIPE_STAGE_SKID_EN
  logic [PW-1:0] skid_q;
  logic          skid_load;
  logic          skid_clear;
  logic          main_from_skid;
  logic          in_ready_q;

  assign main_d = main_from_skid ? skid_q : in_payload;
`else
  assign main_d = in_payload;
`endif

  // State register; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and entry-control decode: flush beats the handshake.
  always_comb begin
    state_n    = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      state_n    = EMPTY;
      main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_load = 1'b1;
            state_n   = FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              main_load = 1'b1;
            end else begin
              main_clear = 1'b1;
              state_n    = EMPTY;
            end
          end else if (in_valid) begin
`ifdef PIPE_STAGE_SKID_EN
            // Downstream stalled but we advertised ready: park the beat in skid.
            skid_load = 1'b1;
            state_n   = SKID;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (out_ready) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_n        = FULL;
          end
        end
`endif
        default: begin
          main_clear = 1'b1;
          state_n    = EMPTY;
        end
      endcase
    end
  end

  pipe_entry #(.WIDTH(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_entry #(.WIDTH(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_payload),
    .q     (skid_q)
  );

  // Registered ready keeps out_ready off the upstream timing path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_n != SKID);
    end
  end

  assign in_ready = in_ready_q;
`else
  assign in_ready = (state == EMPTY) || out_ready;
`endif

  assign out_valid = (state != EMPTY);
  assign out_IR    = out_valid ? main_q[PW-1 -: IR_WIDTH] : IR_WIDTH'(PIPE_NOP_IR);
  assign out_data  = out_valid ? main_q[DW_ALL-1:0] : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table-driven bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_IR;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_IR;
  logic [63:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_WIDTH (32),
    .NUM_FIELDS (2),
    .IR_WIDTH   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_IR     (in_IR),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_IR    (out_IR),
    .out_data  (out_data)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] ir;
    logic [63:0] din;
    logic        ev;
    logic [31:0] eir;
    logic [63:0] edat;
    logic        chk_rdy;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] dat(int k);
    logic [31:0] f0, f1;
    f0 = 32'(k * 16 + 0);
    f1 = 32'(k * 16 + 1);
    return {f1, f0};
  endfunction

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy, int k,
                              logic ev, int ek, logic chk_rdy, logic erdy);
    vec_t v;
    v.rst     = rst;
    v.fl      = fl;
    v.iv      = iv;
    v.ordy    = ordy;
    v.ir      = 32'(k);
    v.din     = dat(k);
    v.ev      = ev;
    v.eir     = ev ? 32'(ek) : 32'h0;
    v.edat    = ev ? dat(ek) : 64'h0;
    v.chk_rdy = chk_rdy;
    v.erdy    = erdy;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic fl, logic iv, logic ordy, int k);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_IR     = 32'(k);
    in_data   = dat(k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string tag, logic ev, int ek);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".out_IR"}, 64'(out_IR), ev ? 64'(ek) : 64'h0);
    chk({tag, ".out_data"}, out_data, ev ? dat(ek) : 64'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);

    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 0, 1, 1, k, 1, k, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 9, 1, 9, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 10, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 1, 11, 1, 11, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 12, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, int'(vecs[i].ir));
      step();
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(vecs[i].ev));
      chk({tag, ".out_IR"}, 64'(out_IR), 64'(vecs[i].eir));
      chk({tag, ".out_data"}, out_data, vecs[i].edat);
      if (vecs[i].chk_rdy)
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(vecs[i].erdy));
    end

    // Backpressure: IR=5 held in main, downstream stalls while IR=6 is offered.
    drive(1, 0, 1, 1, 5);
    step();
    chk_out("bp_load5", 1, 5);
    drive(1, 0, 1, 0, 6);
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_rdy_pre", 64'(in_ready), 64'd1);
    step();
    chk_out("bp_skid", 1, 5);
    chk("bp_rdy_skid", 64'(in_ready), 64'd0);
    drive(1, 0, 0, 1, 0);
    step();
    chk_out("bp_drain6", 1, 6);
    chk("bp_rdy_full", 64'(in_ready), 64'd1);
`else
    chk("bp_rdy_comb", 64'(in_ready), 64'd0);
    step();
    chk_out("bp_hold5", 1, 5);
    chk("bp_rdy_hold", 64'(in_ready), 64'd0);
    drive(1, 0, 1, 1, 6);
    #1;
    chk("bp_rdy_release", 64'(in_ready), 64'd1);
    step();
    chk_out("bp_deliver6", 1, 6);
    drive(1, 0, 0, 1, 0);
`endif
    step();
    chk_out("bp_empty", 0, 0);

    // Flush with traffic: IR=5, 6 and 7 must all vanish.
    drive(1, 0, 1, 1, 5);
    step();
    chk_out("fl_load5", 1, 5);
    drive(1, 0, 1, 0, 6);
    step();
    chk_out("fl_stall5", 1, 5);
    drive(1, 1, 1, 0, 7);
    step();
    chk_out("fl_flush", 0, 0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("fl_idle%0d", i), 0, 0);
    end

    // Reset while FULL with a pending output transfer.
    drive(1, 0, 1, 1, 13);
    step();
    chk_out("rs_load13", 1, 13);
    drive(0, 0, 1, 1, 14);
    step();
    chk_out("rs_reset", 0, 0);
    chk("rs_rdy", 64'(in_ready), 64'd1);
    drive(1, 0, 0, 1, 0);
    step();
    chk_out("rs_idle", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that supersedes the fixed per-stage latches (IR plus fixed 32-bit operand fields). It carries one instruction word plus `NUM_FIELDS` data fields of `DATA_WIDTH` bits between two pipeline stages. It adds a valid/ready handshake, flush-to-NOP bubble insertion and an optional skid entry, so a stall from the downstream stage can be registered instead of rippling combinationally upstream. One instance sits between each pair of stages (FD, DX, XM, MW).

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of each data field
- `NUM_FIELDS`, 2, number of data fields carried (minimum 1)
- `IR_WIDTH`, 32, instruction-word width

Ports:
- `clk`  in  1  rising-edge clock; single clock domain
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge
- `flush`  in  1  synchronous kill of all held entries
- `in_valid`  in  1  upstream presents a transfer
- `in_ready`  out  1  stage can accept; transfer when `in_valid && in_ready`
- `in_IR`  in  `IR_WIDTH`  incoming instruction
- `in_data`  in  `NUM_FIELDS*DATA_WIDTH`  field k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `out_valid`  out  1  output entry valid
- `out_ready`  in  1  downstream accepts; transfer when `out_valid && out_ready`
- `out_IR`  out  `IR_WIDTH`  held instruction; NOP (all zeros) whenever `out_valid`=0
- `out_data`  out  `NUM_FIELDS*DATA_WIDTH`  held fields; zero whenever `out_valid`=0

## Operation
- Storage: main entry (drives the outputs) and, when configured, one skid entry.
- States (skid build): EMPTY (no valid entry), FULL (main valid), SKID (main and skid valid).
  - EMPTY: `in_valid` -> load main, go FULL.
  - FULL, `out_ready && in_valid` -> reload main from input, stay FULL.
  - FULL, `out_ready && !in_valid` -> go EMPTY; clear the payload.
  - FULL, `!out_ready && in_valid` -> capture input into skid, go SKID.
  - FULL, neither -> hold.
  - SKID: `in_ready`=0. On `out_ready`, main <= skid and go FULL.
- Priority: `reset` low > `flush` > handshake.
- `flush`: next state EMPTY. Main and skid payloads are zeroed. Any same-cycle input transfer is dropped, even though `in_ready` may have been 1. Any same-cycle output transfer counts as consumed.
- Ordering: entries leave in arrival order; none is duplicated or lost, except on flush or reset.
- Width rules: fields are opaque. No arithmetic. No sign or zero extension.

## Timing
- Latency: input transfer at edge N means `out_valid` is high after edge N with that payload.
- Throughput: 1 transfer per cycle while `out_ready` is held high.
- Skid build: `in_ready` is a flop output, equal to (state != SKID). There is no combinational path from `out_ready` to `in_ready`.
- Reset (`reset`=0 at an edge): `out_valid`=0, `out_IR`=0, `out_data`=0, skid invalid, and `in_ready`=1 from the first cycle after reset.
- Reset asserted mid-stream: all entries are discarded at that edge, regardless of `flush`, `in_valid` or `out_ready`.
- Outputs are registered only; no input-to-output combinational path, except `in_ready` in the no-skid build.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - the skid entry and SKID state exist
  - `in_ready` is registered as described above
- `PIPE_STAGE_SKID_EN` undefined:
  - no skid storage; only EMPTY and FULL states exist
  - `in_ready = !out_valid || out_ready`, which is combinational
  - all other behaviour is identical, including flush and reset

## Structure
- Shared package `pipe_pkg`:
  - `PIPE_NOP_IR` = 32'h0000_0000
  - default width constants
  - the stage-state enum {EMPTY, FULL, SKID}
- Sub-module `pipe_entry`: one enable-and-clear register holding {IR, data}. It is instantiated once for main and once more for skid under the macro.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, then release with `in_valid`=0 -> `out_valid`=0, `out_IR`=0, `out_data`=0, `in_ready`=1.
- Streaming: send IR=1..8, data=k*16+field, with `out_ready`=1 every cycle -> outputs appear 1 cycle later in order, one per cycle, with no bubbles.
- Backpressure (skid): in the FULL state with IR=5 held, drop `out_ready` and present IR=6 -> state SKID, `in_ready`=0 next cycle. Raise `out_ready` -> IR=5 then IR=6 are delivered; nothing is lost or duplicated.
- Flush with traffic: in SKID (IR=5 main, IR=6 skid), assert `flush` with `in_valid`=1, IR=7 -> next cycle `out_valid`=0 and `out_IR`=0. IR=5, 6 and 7 never appear.
- Reset mid-stream: assert `reset`=0 while FULL with `out_ready`=1 -> the outputs match the reset values the next cycle and no transfer is reported.
- No-skid build: repeat the backpressure case -> `in_ready` falls in the same cycle as `out_ready` falls while FULL, and IR=6 waits upstream.
